// File: rtl/mor1kx_tlb_reload_pkg.sv
// Shared definitions for the TLB reload bridge: FSM encoding, requester ids
// and the fixed Wishbone classic read attributes.
package mor1kx_tlb_reload_pkg;

  localparam int unsigned WB_SEL_W = 4;
  localparam int unsigned WB_CTI_W = 3;
  localparam int unsigned WB_BTE_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    RESP  = 2'd2,
    RETRY = 2'd3
  } state_t;

  localparam logic REQ_DMMU = 1'b0;
  localparam logic REQ_IMMU = 1'b1;

  // Single-beat classic cycle, full-word read.
  localparam logic [WB_SEL_W-1:0] WB_SEL = 4'hf;
  localparam logic [WB_CTI_W-1:0] WB_CTI = 3'b000;
  localparam logic [WB_BTE_W-1:0] WB_BTE = 2'b00;

endpackage

// File: rtl/mor1kx_tlb_reload_arb.sv
// Two-way round-robin arbiter between the DMMU and IMMU reload requesters.
// Ports:
//   clk, rst         clock, async active-low reset
//   req_dmmu_i       DMMU request
//   req_immu_i       IMMU request
//   gnt_en_i         commit the current grant into the last-grant register
//   gnt_valid_c      some request is pending (combinational)
//   gnt_id_c         winning requester id (combinational)
module mor1kx_tlb_reload_arb
  import mor1kx_tlb_reload_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_dmmu_i,
  input  logic req_immu_i,
  input  logic gnt_en_i,
  output logic gnt_valid_c,
  output logic gnt_id_c
);

  logic last_q;
  logic last_d;

  // On a tie the requester that was not served last wins.
  always_comb begin
    gnt_valid_c = req_dmmu_i | req_immu_i;
    if (req_dmmu_i && req_immu_i) begin
      gnt_id_c = ~last_q;
    end else if (req_immu_i) begin
      gnt_id_c = REQ_IMMU;
    end else begin
      gnt_id_c = REQ_DMMU;
    end
    last_d = last_q;
    if (gnt_en_i && gnt_valid_c) begin
      last_d = gnt_id_c;
    end
  end

  // Reset points at the IMMU so the first tie goes to the DMMU.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= REQ_IMMU;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mor1kx_tlb_reload_bridge.sv
// TLB reload bridge: arbitrates DMMU/IMMU reload requests, turns each grant
// into one Wishbone B3 classic read and returns the word with a one-cycle ack.
// Bus error or timeout returns data 0 with err set, which the MMU sees as a
// pagefault.
// Optional feature: define MOR1KX_TLB_RELOAD_PTR_CACHE_EN for a one-entry
// read cache (hits answer without a bus cycle; flush_i invalidates).
// Ports:
//   clk, rst                      clock, async active-low reset
//   dmmu_req_i/addr_i             DMMU request and word address
//   dmmu_ack_o/data_o/err_o       DMMU response strobe, word, error flag
//   immu_*                        same for the IMMU
//   flush_i                       pointer cache invalidate
//   wbm_*                         Wishbone B3 classic master
module mor1kx_tlb_reload_bridge
  import mor1kx_tlb_reload_pkg::*;
#(
  parameter int unsigned OPTION_OPERAND_WIDTH = 32,
  parameter int unsigned OPTION_TIMEOUT_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            dmmu_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] dmmu_addr_i,
  output logic                            dmmu_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] dmmu_data_o,
  output logic                            dmmu_err_o,
  input  logic                            immu_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] immu_addr_i,
  output logic                            immu_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] immu_data_o,
  output logic                            immu_err_o,
  input  logic                            flush_i,
  output logic [OPTION_OPERAND_WIDTH-1:0] wbm_adr_o,
  output logic                            wbm_cyc_o,
  output logic                            wbm_stb_o,
  output logic                            wbm_we_o,
  output logic [WB_SEL_W-1:0]             wbm_sel_o,
  output logic [WB_CTI_W-1:0]             wbm_cti_o,
  output logic [WB_BTE_W-1:0]             wbm_bte_o,
  input  logic [OPTION_OPERAND_WIDTH-1:0] wbm_dat_i,
  input  logic                            wbm_ack_i,
  input  logic                            wbm_err_i,
  input  logic                            wbm_rty_i
);

  localparam int unsigned AW = OPTION_OPERAND_WIDTH;
  localparam int unsigned TW = OPTION_TIMEOUT_WIDTH;

  state_t          state_q, state_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic            id_q, id_d;
  logic            abort_q, abort_d;
  logic            cyc_q, cyc_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            dmmu_ack_q, dmmu_ack_d;
  logic            dmmu_err_q, dmmu_err_d;
  logic [AW-1:0]   dmmu_data_q, dmmu_data_d;
  logic            immu_ack_q, immu_ack_d;
  logic            immu_err_q, immu_err_d;
  logic [AW-1:0]   immu_data_q, immu_data_d;

  logic            gnt_valid_c;
  logic            gnt_id_c;
  logic [AW-1:0]   sel_addr_c;
  logic            gnt_req_c;
  logic            aborting_c;
  logic            hit_c;
  logic [AW-1:0]   cache_data_c;
  logic            refill_c;
  logic            resp_en_c;
  logic            resp_err_c;
  logic [AW-1:0]   resp_data_c;
  logic            unused_c;

  mor1kx_tlb_reload_arb u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_dmmu_i  (dmmu_req_i),
    .req_immu_i  (immu_req_i),
    .gnt_en_i    (state_q == IDLE),
    .gnt_valid_c (gnt_valid_c),
    .gnt_id_c    (gnt_id_c)
  );

  assign sel_addr_c = (gnt_id_c == REQ_DMMU) ? dmmu_addr_i : immu_addr_i;
  assign gnt_req_c  = (id_q == REQ_DMMU) ? dmmu_req_i : immu_req_i;
  // Once the owner lets go the response is dropped, but the bus cycle finishes.
  assign aborting_c = abort_q | ~gnt_req_c;

`ifdef MOR1KX_TLB_RELOAD_PTR_CACHE_EN
  logic            cache_valid_q, cache_valid_d;
  logic [AW-3:0]   cache_tag_q, cache_tag_d;
  logic [AW-1:0]   cache_data_q, cache_data_d;

  assign hit_c        = cache_valid_q & ~flush_i & (cache_tag_q == sel_addr_c[AW-1:2]);
  assign cache_data_c = cache_data_q;

  // Refill on every good bus read; a same-cycle flush leaves the entry invalid.
  always_comb begin
    cache_valid_d = cache_valid_q;
    cache_tag_d   = cache_tag_q;
    cache_data_d  = cache_data_q;
    if (refill_c) begin
      cache_valid_d = 1'b1;
      cache_tag_d   = adr_q[AW-1:2];
      cache_data_d  = wbm_dat_i;
    end
    if (flush_i) begin
      cache_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cache_valid_q <= 1'b0;
      cache_tag_q   <= '0;
      cache_data_q  <= '0;
    end else begin
      cache_valid_q <= cache_valid_d;
      cache_tag_q   <= cache_tag_d;
      cache_data_q  <= cache_data_d;
    end
  end

  assign unused_c = ^{sel_addr_c[1:0]};
`else
  assign hit_c        = 1'b0;
  assign cache_data_c = '0;
  assign unused_c     = ^{sel_addr_c[1:0], flush_i, refill_c};
`endif

  // Next-state and response logic.
  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    id_d        = id_q;
    abort_d     = abort_q;
    cyc_d       = cyc_q;
    tmo_d       = tmo_q;
    dmmu_ack_d  = 1'b0;
    dmmu_err_d  = 1'b0;
    dmmu_data_d = '0;
    immu_ack_d  = 1'b0;
    immu_err_d  = 1'b0;
    immu_data_d = '0;
    refill_c    = 1'b0;
    resp_en_c   = 1'b0;
    resp_err_c  = 1'b0;
    resp_data_c = '0;

    case (state_q)
      IDLE: begin
        if (gnt_valid_c) begin
          adr_d   = {sel_addr_c[AW-1:2], 2'b00};
          id_d    = gnt_id_c;
          abort_d = 1'b0;
          tmo_d   = '0;
          if (hit_c) begin
            state_d     = RESP;
            resp_en_c   = 1'b1;
            resp_data_c = cache_data_c;
          end else begin
            state_d = BUS;
            cyc_d   = 1'b1;
          end
        end
      end
      BUS: begin
        tmo_d = tmo_q + TW'(1);
        if (!gnt_req_c) begin
          abort_d = 1'b1;
        end
        if (wbm_ack_i) begin
          cyc_d    = 1'b0;
          refill_c = 1'b1;
          if (aborting_c) begin
            state_d = IDLE;
          end else begin
            state_d     = RESP;
            resp_en_c   = 1'b1;
            resp_data_c = wbm_dat_i;
          end
        end else if (wbm_err_i || (tmo_d == {TW{1'b1}})) begin
          // Zero data makes the MMU take a pagefault.
          cyc_d = 1'b0;
          if (aborting_c) begin
            state_d = IDLE;
          end else begin
            state_d    = RESP;
            resp_en_c  = 1'b1;
            resp_err_c = 1'b1;
          end
        end else if (wbm_rty_i) begin
          cyc_d   = 1'b0;
          state_d = aborting_c ? IDLE : RETRY;
        end
      end
      RETRY: begin
        cyc_d   = 1'b1;
        tmo_d   = '0;
        state_d = BUS;
      end
      RESP: begin
        state_d = IDLE;
      end
    endcase

    if (resp_en_c) begin
      if (id_d == REQ_DMMU) begin
        dmmu_ack_d  = 1'b1;
        dmmu_err_d  = resp_err_c;
        dmmu_data_d = resp_data_c;
      end else begin
        immu_ack_d  = 1'b1;
        immu_err_d  = resp_err_c;
        immu_data_d = resp_data_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      adr_q       <= '0;
      id_q        <= REQ_DMMU;
      abort_q     <= 1'b0;
      cyc_q       <= 1'b0;
      tmo_q       <= '0;
      dmmu_ack_q  <= 1'b0;
      dmmu_err_q  <= 1'b0;
      dmmu_data_q <= '0;
      immu_ack_q  <= 1'b0;
      immu_err_q  <= 1'b0;
      immu_data_q <= '0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      id_q        <= id_d;
      abort_q     <= abort_d;
      cyc_q       <= cyc_d;
      tmo_q       <= tmo_d;
      dmmu_ack_q  <= dmmu_ack_d;
      dmmu_err_q  <= dmmu_err_d;
      dmmu_data_q <= dmmu_data_d;
      immu_ack_q  <= immu_ack_d;
      immu_err_q  <= immu_err_d;
      immu_data_q <= immu_data_d;
    end
  end

  assign dmmu_ack_o  = dmmu_ack_q;
  assign dmmu_err_o  = dmmu_err_q;
  assign dmmu_data_o = dmmu_data_q;
  assign immu_ack_o  = immu_ack_q;
  assign immu_err_o  = immu_err_q;
  assign immu_data_o = immu_data_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = 1'b0;
  assign wbm_sel_o   = WB_SEL;
  assign wbm_cti_o   = WB_CTI;
  assign wbm_bte_o   = WB_BTE;

endmodule

// File: tb/tb_mor1kx_tlb_reload_bridge.sv
// Directed bench for mor1kx_tlb_reload_bridge with a behavioural Wishbone slave.
module tb_mor1kx_tlb_reload_bridge;

  localparam int M_SILENT = 0;
  localparam int M_ACK    = 1;
  localparam int M_ERR    = 2;
  localparam int M_RTY    = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        dmmu_req_i, immu_req_i, flush_i;
  logic [31:0] dmmu_addr_i, immu_addr_i;
  logic        dmmu_ack_o, dmmu_err_o, immu_ack_o, immu_err_o;
  logic [31:0] dmmu_data_o, immu_data_o;
  logic [31:0] wbm_adr_o, wbm_dat_i;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic        wbm_ack_i, wbm_err_i, wbm_rty_i;

  int          slv_mode = M_SILENT;
  logic [31:0] slv_key  = 32'h0;
  int          rty_mark = 0;
  int          cyc_starts = 0;
  int          dmmu_acks = 0;
  int          immu_acks = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  mor1kx_tlb_reload_bridge dut (
    .clk         (clk),
    .rst         (rst),
    .dmmu_req_i  (dmmu_req_i),
    .dmmu_addr_i (dmmu_addr_i),
    .dmmu_ack_o  (dmmu_ack_o),
    .dmmu_data_o (dmmu_data_o),
    .dmmu_err_o  (dmmu_err_o),
    .immu_req_i  (immu_req_i),
    .immu_addr_i (immu_addr_i),
    .immu_ack_o  (immu_ack_o),
    .immu_data_o (immu_data_o),
    .immu_err_o  (immu_err_o),
    .flush_i     (flush_i),
    .wbm_adr_o   (wbm_adr_o),
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_we_o    (wbm_we_o),
    .wbm_sel_o   (wbm_sel_o),
    .wbm_cti_o   (wbm_cti_o),
    .wbm_bte_o   (wbm_bte_o),
    .wbm_dat_i   (wbm_dat_i),
    .wbm_ack_i   (wbm_ack_i),
    .wbm_err_i   (wbm_err_i),
    .wbm_rty_i   (wbm_rty_i)
  );

  // Bus cycles counted at the rising edge of cyc.
  always @(posedge wbm_cyc_o) cyc_starts = cyc_starts + 1;

  always @(posedge clk) begin
    if (dmmu_ack_o) dmmu_acks <= dmmu_acks + 1;
    if (immu_ack_o) immu_acks <= immu_acks + 1;
  end

  // Zero-wait slave; data is the address xor a key. In retry mode the first
  // cycle after rty_mark is retried and later ones are acked.
  always_comb begin
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    wbm_rty_i = 1'b0;
    wbm_dat_i = wbm_adr_o ^ slv_key;
    if (wbm_cyc_o && wbm_stb_o) begin
      case (slv_mode)
        M_ACK: wbm_ack_i = 1'b1;
        M_ERR: wbm_err_i = 1'b1;
        M_RTY: begin
          if (cyc_starts == rty_mark + 1) wbm_rty_i = 1'b1;
          else wbm_ack_i = 1'b1;
        end
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input logic which, input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(which ? immu_ack_o : dmmu_ack_o) && n < max);
  endtask

  initial begin
    int          n, s0, a0, hi, k, a;
    logic        prev_cyc;
    logic [31:0] adr_seen [3];
    logic [31:0] dat_seen [3];
    logic        id_seen  [3];

    rst = 1'b0;
    dmmu_req_i = 1'b0; immu_req_i = 1'b0; flush_i = 1'b0;
    dmmu_addr_i = 32'h0; immu_addr_i = 32'h0;
    repeat (3) @(negedge clk);

    // Reset state and constant bus attributes
    chk("rst_cyc",   32'(wbm_cyc_o), 32'd0);
    chk("rst_stb",   32'(wbm_stb_o), 32'd0);
    chk("rst_adr",   wbm_adr_o, 32'h0);
    chk("rst_dack",  32'(dmmu_ack_o), 32'd0);
    chk("rst_iack",  32'(immu_ack_o), 32'd0);
    chk("rst_ddata", dmmu_data_o, 32'h0);
    chk("rst_ierr",  32'(immu_err_o), 32'd0);
    chk("we",        32'(wbm_we_o), 32'd0);
    chk("sel",       32'(wbm_sel_o), 32'hf);
    chk("cti",       32'(wbm_cti_o), 32'd0);
    chk("bte",       32'(wbm_bte_o), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single DMMU read, zero-wait slave
    slv_mode = M_ACK; slv_key = 32'hDEAD_B004;
    dmmu_addr_i = 32'h0000_1004; dmmu_req_i = 1'b1;
    @(negedge clk);
    chk("t1_adr",  wbm_adr_o, 32'h0000_1004);
    chk("t1_cyc",  32'(wbm_cyc_o), 32'd1);
    chk("t1_stb",  32'(wbm_stb_o), 32'd1);
    chk("t1_dack0", 32'(dmmu_ack_o), 32'd0);
    @(negedge clk);
    chk("t1_dack", 32'(dmmu_ack_o), 32'd1);
    chk("t1_data", dmmu_data_o, 32'hDEAD_A000);
    chk("t1_derr", 32'(dmmu_err_o), 32'd0);
    chk("t1_iack", 32'(immu_ack_o), 32'd0);
    chk("t1_cyc_low", 32'(wbm_cyc_o), 32'd0);
    dmmu_req_i = 1'b0;
    @(negedge clk);
    chk("t1_dack_pulse", 32'(dmmu_ack_o), 32'd0);
    chk("t1_data_clr", dmmu_data_o, 32'h0);

    // Round robin with both requests held; IMMU low address bits ignored
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    slv_key = 32'h0BAD_0000;
    dmmu_addr_i = 32'h100; immu_addr_i = 32'h202;
    dmmu_req_i = 1'b1; immu_req_i = 1'b1;
    k = 0; a = 0; n = 0; prev_cyc = 1'b0;
    while (a < 3 && n < 30) begin
      @(negedge clk);
      n++;
      if (wbm_cyc_o && !prev_cyc && k < 3) begin
        adr_seen[k] = wbm_adr_o;
        k++;
      end
      prev_cyc = wbm_cyc_o;
      if (dmmu_ack_o || immu_ack_o) begin
        id_seen[a]  = immu_ack_o;
        dat_seen[a] = immu_ack_o ? immu_data_o : dmmu_data_o;
        a++;
      end
    end
    dmmu_req_i = 1'b0; immu_req_i = 1'b0;
    chk("rr_cycles", 32'(n), 32'd8);
    chk("rr_adr0", adr_seen[0], 32'h100);
    chk("rr_adr1", adr_seen[1], 32'h200);
    chk("rr_adr2", adr_seen[2], 32'h100);
    chk("rr_id0", 32'(id_seen[0]), 32'd0);
    chk("rr_id1", 32'(id_seen[1]), 32'd1);
    chk("rr_id2", 32'(id_seen[2]), 32'd0);
    chk("rr_dat0", dat_seen[0], 32'h0BAD_0100);
    chk("rr_dat1", dat_seen[1], 32'h0BAD_0200);
    chk("rr_dat2", dat_seen[2], 32'h0BAD_0100);
    repeat (2) @(negedge clk);

    // Bus error
    slv_mode = M_ERR;
    dmmu_addr_i = 32'h300; dmmu_req_i = 1'b1;
    wait_ack(1'b0, 10, n);
    chk("err_lat",  32'(n), 32'd2);
    chk("err_ack",  32'(dmmu_ack_o), 32'd1);
    chk("err_data", dmmu_data_o, 32'h0);
    chk("err_flag", 32'(dmmu_err_o), 32'd1);
    dmmu_req_i = 1'b0;
    @(negedge clk);
    chk("err_flag_clr", 32'(dmmu_err_o), 32'd0);
    @(negedge clk);

    // Timeout: silent slave
    slv_mode = M_SILENT;
    dmmu_addr_i = 32'h500; dmmu_req_i = 1'b1;
    n = 0; hi = 0;
    do begin
      @(negedge clk);
      n++;
      if (wbm_cyc_o) hi++;
    end while (!dmmu_ack_o && n < 400);
    chk("tmo_cyc_len", 32'(hi), 32'd255);
    chk("tmo_ack",  32'(dmmu_ack_o), 32'd1);
    chk("tmo_err",  32'(dmmu_err_o), 32'd1);
    chk("tmo_data", dmmu_data_o, 32'h0);
    dmmu_req_i = 1'b0;
    repeat (2) @(negedge clk);

    // One retry, then ack
    slv_mode = M_RTY; slv_key = 32'h5500_0000;
    rty_mark = cyc_starts; s0 = cyc_starts; a0 = dmmu_acks;
    dmmu_addr_i = 32'h600; dmmu_req_i = 1'b1;
    @(negedge clk);
    chk("rty_cyc1", 32'(wbm_cyc_o), 32'd1);
    chk("rty_adr1", wbm_adr_o, 32'h600);
    @(negedge clk);
    chk("rty_gap",  32'(wbm_cyc_o), 32'd0);
    @(negedge clk);
    chk("rty_cyc2", 32'(wbm_cyc_o), 32'd1);
    chk("rty_adr2", wbm_adr_o, 32'h600);
    @(negedge clk);
    chk("rty_ack",  32'(dmmu_ack_o), 32'd1);
    chk("rty_data", dmmu_data_o, 32'h5500_0600);
    dmmu_req_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rty_ack_count", 32'(dmmu_acks - a0), 32'd1);
    chk("rty_bus_count", 32'(cyc_starts - s0), 32'd2);

    // Requester drops request mid-bus-cycle
    slv_mode = M_SILENT; slv_key = 32'h1234_0000;
    s0 = cyc_starts; a0 = dmmu_acks;
    dmmu_addr_i = 32'h700; dmmu_req_i = 1'b1;
    @(negedge clk);
    chk("abt_cyc", 32'(wbm_cyc_o), 32'd1);
    @(negedge clk);
    dmmu_req_i = 1'b0;
    @(negedge clk);
    chk("abt_cyc_held", 32'(wbm_cyc_o), 32'd1);
    slv_mode = M_ACK;
    @(negedge clk);
    chk("abt_cyc_done", 32'(wbm_cyc_o), 32'd0);
    chk("abt_no_ack",   32'(dmmu_ack_o), 32'd0);
    repeat (3) @(negedge clk);
    chk("abt_ack_count", 32'(dmmu_acks - a0), 32'd0);
    chk("abt_bus_count", 32'(cyc_starts - s0), 32'd1);
    dmmu_addr_i = 32'h800; dmmu_req_i = 1'b1;
    wait_ack(1'b0, 10, n);
    chk("abt_next_lat",  32'(n), 32'd2);
    chk("abt_next_data", dmmu_data_o, 32'h1234_0800);
    dmmu_req_i = 1'b0;
    repeat (2) @(negedge clk);

    // Back-to-back reads of the same address
    slv_key = 32'h1234_5678;
    s0 = cyc_starts;
    dmmu_addr_i = 32'h400; dmmu_req_i = 1'b1;
    wait_ack(1'b0, 10, n);
    chk("rep_lat1",  32'(n), 32'd2);
    chk("rep_data1", dmmu_data_o, 32'h1234_5278);
    wait_ack(1'b0, 10, n);
`ifdef MOR1KX_TLB_RELOAD_PTR_CACHE_EN
    chk("rep_lat2", 32'(n), 32'd2);
    chk("rep_bus_count", 32'(cyc_starts - s0), 32'd1);
`else
    chk("rep_lat2", 32'(n), 32'd3);
    chk("rep_bus_count", 32'(cyc_starts - s0), 32'd2);
`endif
    chk("rep_data2", dmmu_data_o, 32'h1234_5278);
    dmmu_req_i = 1'b0;
    @(negedge clk);

`ifdef MOR1KX_TLB_RELOAD_PTR_CACHE_EN
    // Flush forces a fresh bus read
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    s0 = cyc_starts;
    dmmu_req_i = 1'b1;
    wait_ack(1'b0, 10, n);
    chk("flush_lat", 32'(n), 32'd2);
    chk("flush_bus_count", 32'(cyc_starts - s0), 32'd1);
    chk("flush_data", dmmu_data_o, 32'h1234_5278);
    dmmu_req_i = 1'b0;
    @(negedge clk);

    // Flush coinciding with a refill leaves the entry invalid
    s0 = cyc_starts;
    flush_i = 1'b1;
    dmmu_addr_i = 32'h440; dmmu_req_i = 1'b1;
    wait_ack(1'b0, 10, n);
    flush_i = 1'b0;
    wait_ack(1'b0, 10, n);
    chk("flush_refill_lat", 32'(n), 32'd3);
    chk("flush_refill_bus", 32'(cyc_starts - s0), 32'd2);
    dmmu_req_i = 1'b0;
    @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
